// File: rtl/mem_bus_pkg.sv
// Shared definitions for the RAM port arbiter slice.
//   arb_state_t            : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   GRANT_FETCH/GRANT_DATA : grant / round-robin identifiers
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit in busy WAIT cycles
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_req_latch.sv
// Per-requester capture and result stage.
//   request/write/address/writeData : one-cycle request pulse and its operands
//   complete/completeData           : arbiter finishing this port's transaction
//   busy                            : request pending or in flight
//   latchWrite/latchAddress/latchWriteData : captured operands
//   resultData                      : read result, held until next completion
//   valid                           : one-cycle completion pulse
module mem_req_latch #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned WORD_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     request,
    input  logic                     write,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0]    writeData,
    input  logic                     complete,
    input  logic [WORD_WIDTH-1:0]    completeData,
    output logic                     busy,
    output logic                     latchWrite,
    output logic [ADDRESS_WIDTH-1:0] latchAddress,
    output logic [WORD_WIDTH-1:0]    latchWriteData,
    output logic [WORD_WIDTH-1:0]    resultData,
    output logic                     valid
);

    // complete only arrives while busy, and requests are ignored while busy,
    // so the two branches never compete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy           <= 1'b0;
            latchWrite     <= 1'b0;
            latchAddress   <= '0;
            latchWriteData <= '0;
            resultData     <= '0;
            valid          <= 1'b0;
        end else begin
            valid <= complete;
            if (complete) begin
                busy <= 1'b0;
                if (!latchWrite) begin
                    resultData <= completeData;
                end
            end else if (request && !busy) begin
                busy           <= 1'b1;
                latchWrite     <= write;
                latchAddress   <= address;
                latchWriteData <= writeData;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between instruction fetch and the load/store unit.
//   fetch*  : fetch requester (read only), result fetchData + fetchValid
//   data*   : load/store requester, result dataReadData + dataValid
//   ram*    : RAM side; ramRequest pulses for one cycle, address/data held
//   timeoutError : pulses with the valid of a transaction aborted by the watchdog
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetchRequest,
    input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
    output logic                     fetchBusy,
    output logic [WORD_WIDTH-1:0]    fetchData,
    output logic                     fetchValid,
    input  logic                     dataRequest,
    input  logic                     dataWrite,
    input  logic [ADDRESS_WIDTH-1:0] dataAddress,
    input  logic [WORD_WIDTH-1:0]    dataWriteData,
    output logic                     dataBusy,
    output logic [WORD_WIDTH-1:0]    dataReadData,
    output logic                     dataValid,
    output logic                     timeoutError,
    output logic                     ramRequest,
    output logic                     ramWrite,
    output logic [ADDRESS_WIDTH-1:0] ramAddress,
    output logic [WORD_WIDTH-1:0]    ramWriteData,
    input  logic [WORD_WIDTH-1:0]    ramData,
    input  logic                     ramBusy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t             state;
    logic                   grant;
    logic                   lastGrant;
    logic [WD_W-1:0]        watchdog;

    logic                     fetchLatchWrite, dataLatchWrite;
    logic [ADDRESS_WIDTH-1:0] fetchLatchAddress, dataLatchAddress;
    logic [WORD_WIDTH-1:0]    fetchLatchWriteData, dataLatchWriteData;

    logic                  bothPending;
    logic                  winner;
    logic                  abort;
    logic                  finish;
    logic                  fetchComplete, dataComplete;
    logic [WORD_WIDTH-1:0] completeData;

    always_comb begin
        bothPending   = fetchBusy && dataBusy;
        winner        = bothPending ? ~lastGrant : (dataBusy ? GRANT_DATA : GRANT_FETCH);
        // Abort on the busy WAIT edge that would bring the count to TIMEOUT_CYCLES.
        abort         = (state == ARB_WAIT) && ramBusy && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
        finish        = (state == ARB_WAIT) && (!ramBusy || abort);
        fetchComplete = finish && (grant == GRANT_FETCH);
        dataComplete  = finish && (grant == GRANT_DATA);
        completeData  = abort ? '0 : ramData;
    end

    mem_req_latch #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_fetch_latch (
        .clk           (clk),
        .reset         (reset),
        .request       (fetchRequest),
        .write         (1'b0),
        .address       (fetchAddress),
        .writeData     ('0),
        .complete      (fetchComplete),
        .completeData  (completeData),
        .busy          (fetchBusy),
        .latchWrite    (fetchLatchWrite),
        .latchAddress  (fetchLatchAddress),
        .latchWriteData(fetchLatchWriteData),
        .resultData    (fetchData),
        .valid         (fetchValid)
    );

    mem_req_latch #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_data_latch (
        .clk           (clk),
        .reset         (reset),
        .request       (dataRequest),
        .write         (dataWrite),
        .address       (dataAddress),
        .writeData     (dataWriteData),
        .complete      (dataComplete),
        .completeData  (completeData),
        .busy          (dataBusy),
        .latchWrite    (dataLatchWrite),
        .latchAddress  (dataLatchAddress),
        .latchWriteData(dataLatchWriteData),
        .resultData    (dataReadData),
        .valid         (dataValid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            grant        <= GRANT_FETCH;
            lastGrant    <= GRANT_DATA;
            watchdog     <= '0;
            ramRequest   <= 1'b0;
            ramWrite     <= 1'b0;
            ramAddress   <= '0;
            ramWriteData <= '0;
            timeoutError <= 1'b0;
        end else begin
            ramRequest   <= 1'b0;
            timeoutError <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (fetchBusy || dataBusy) begin
                        grant <= winner;
                        // Round-robin pointer only moves when there was a real contest.
                        if (bothPending) begin
                            lastGrant <= winner;
                        end
                        // RAM operands are registered here so they are stable for ISSUE and WAIT.
                        ramRequest   <= 1'b1;
                        ramWrite     <= (winner == GRANT_DATA) ? dataLatchWrite     : fetchLatchWrite;
                        ramAddress   <= (winner == GRANT_DATA) ? dataLatchAddress   : fetchLatchAddress;
                        ramWriteData <= (winner == GRANT_DATA) ? dataLatchWriteData : fetchLatchWriteData;
                        state        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    watchdog <= '0;
                    state    <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (finish) begin
                        timeoutError <= abort;
                        state        <= ARB_IDLE;
                    end else if (ramBusy) begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
